ahb2apb_bridge_mslv: RTL

Parametrised AHB-to-APB3 bridge. It converts single AHB transfers (NONSEQ/SEQ) into APB SETUP/ACCESS cycles across NUM_SLAVES decoded APB slaves. It adds APB wait-state support (pready), a slave-error path (pslverr), decode-miss detection, and the AHB two-cycle ERROR response. It sits between the AHB master/interconnect and the APB peripheral cluster, replacing the fixed 3-slave bridge datapath.

---
 rtl/ahb2apb_bridge_mslv.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb2apb_bridge_mslv.sv
// rtl/ahb2apb_bridge_mslv.sv - AHB to APB3 bridge with multi-slave decode, wait states and error response
//
// Purpose: converts single AHB transfers (NONSEQ/SEQ) into APB SETUP/ACCESS
// cycles on one of NUM_SLAVES decoded APB slaves. Slave index comes from
// haddr[SEL_LSB +: SEL_BITS]. Decode misses and pslverr are returned as the
// two-cycle AHB ERROR response.
//
// Optional feature macro: AHB2APB_PSTRB_EN adds the pstrb byte-strobe output.
//
// Ports:
//   hclk, hresetn            clock, async active-low reset
//   hreadyin, htrans, hwrite, hsize, hburst, haddr, hwdata   AHB slave inputs
//   hrdata, hreadyout, hresp AHB slave outputs
//   psel, penable, paddr, pwrite, pwdata   APB master outputs
//   prdata, pready, pslverr  per-slave APB inputs (slave i at slice i)
//   pstrb                    APB write strobes (AHB2APB_PSTRB_EN only)

module ahb2apb_bridge_mslv #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_LSB    = 12
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic                             hreadyin,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic [2:0]                       hsize,
  input  logic [2:0]                       hburst,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hreadyout,
  output logic [1:0]                       hresp,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
`ifdef AHB2APB_PSTRB_EN
  output logic [DATA_WIDTH/8-1:0]          pstrb,
`endif
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    valid_xfer;
  logic                    decode_miss;
  logic                    apb_active;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // hburst is accepted but every beat is handled as a single transfer;
  // htrans[0] only distinguishes SEQ/NONSEQ and BUSY/IDLE, which act alike here.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, htrans[0], hsize};

  assign valid_xfer  = (state_q == S_IDLE) && hreadyin && htrans[1];
  // Widened by one bit so NUM_SLAVES equal to a power of two still compares cleanly.
  assign decode_miss = ({1'b0, idx_q} >= (SEL_BITS+1)'(NUM_SLAVES));
  assign apb_active  = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // Only the addressed slave's handshake and data are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (valid_xfer) begin
          addr_d  = haddr;
          write_d = hwrite;
          idx_d   = haddr[SEL_LSB +: SEL_BITS];
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        wdata_d = hwdata;
        state_d = decode_miss ? S_ERR1 : S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            if (!write_q) begin
              rdata_d = sel_rdata;
            end
            state_d = S_IDLE;
          end
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // All outputs decode registered state, so reset clears them immediately.
  assign hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  assign hrdata    = rdata_q;
  assign penable   = (state_q == S_ACCESS);
  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;

  always_comb begin
    psel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel[i] = apb_active && (idx_q == SEL_BITS'(i));
    end
  end

`ifdef AHB2APB_PSTRB_EN
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int OFF_BITS = (STRB_W > 1) ? $clog2(STRB_W) : 1;

  logic [2:0]          size_q;
  logic [OFF_BITS-1:0] strb_off;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      size_q <= '0;
    end else if (valid_xfer) begin
      size_q <= hsize;
    end
  end

  assign strb_off = addr_q[OFF_BITS-1:0];

  // (1 << size) bytes starting at the byte offset; oversize transfers strobe every lane.
  always_comb begin
    pstrb = '0;
    if (apb_active && write_q) begin
      if (int'(size_q) > OFF_BITS) begin
        pstrb = '1;
      end else begin
        for (int b = 0; b < STRB_W; b++) begin
          pstrb[b] = (b >= int'(strb_off)) && (b < int'(strb_off) + (1 << size_q));
        end
      end
    end
  end
`endif

endmodule
